// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite constants and the default-slave state encoding.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DsIdle = 2'b00,
        DsErr1 = 2'b01,
        DsErr2 = 2'b10
    } ds_state_e;

endpackage

// File: rtl/ahbl_default_slave.sv
// Default slave for unmapped accesses: answers with the two-cycle AHB ERROR response.
module ahbl_default_slave
    import ahbl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic hready,
    input  logic decerr_a,
    output logic hready_resp,
    output logic hresp,
    output logic err_active
);

    ds_state_e r_state;
    logic      r_hready_resp;
    logic      r_hresp;
    logic      r_err_active;

    // ERROR FSM with registered outputs; ERR2 may chain straight into another error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= DsIdle;
            r_hready_resp <= 1'b1;
            r_hresp       <= HRESP_OKAY;
            r_err_active  <= 1'b0;
        end else begin
            unique case (r_state)
                DsIdle: begin
                    if (hready && decerr_a) begin
                        r_state       <= DsErr1;
                        r_hready_resp <= 1'b0;
                        r_hresp       <= HRESP_ERROR;
                        r_err_active  <= 1'b1;
                    end
                end
                DsErr1: begin
                    r_state       <= DsErr2;
                    r_hready_resp <= 1'b1;
                    r_hresp       <= HRESP_ERROR;
                    r_err_active  <= 1'b1;
                end
                DsErr2: begin
                    if (hready && decerr_a) begin
                        r_state       <= DsErr1;
                        r_hready_resp <= 1'b0;
                        r_hresp       <= HRESP_ERROR;
                        r_err_active  <= 1'b1;
                    end else begin
                        r_state       <= DsIdle;
                        r_hready_resp <= 1'b1;
                        r_hresp       <= HRESP_OKAY;
                        r_err_active  <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= DsIdle;
                    r_hready_resp <= 1'b1;
                    r_hresp       <= HRESP_OKAY;
                    r_err_active  <= 1'b0;
                end
            endcase
        end
    end

    assign hready_resp = r_hready_resp;
    assign hresp       = r_hresp;
    assign err_active  = r_err_active;

endmodule

// File: rtl/onehot_mux.sv
// Generic AND-OR multiplexer driven by a one-hot (or all-zero) select.
module onehot_mux #(
    parameter int unsigned N = 2,
    parameter int unsigned W = 1
) (
    input  logic [N-1:0]   sel,
    input  logic [N*W-1:0] din,
    output logic [W-1:0]   dout
);

    // OR together every lane whose select bit is set; all-zero select yields zero.
    always_comb begin
        dout = '0;
        for (int unsigned i = 0; i < N; i++) begin
            dout = dout | (din[i*W +: W] & {W{sel[i]}});
        end
    end

endmodule

// File: rtl/ahbl_splitter.sv
// 1:N AHB-Lite address decoder / splitter with an internal ERROR default slave.
// Optional macro AHBL_SPLITTER_DECERR_LOG_EN adds a sticky first-decode-error address log.
module ahbl_splitter
    import ahbl_pkg::*;
#(
    parameter int unsigned               N_PORTS   = 2,
    parameter int unsigned               W_ADDR    = 32,
    parameter int unsigned               W_DATA    = 32,
    parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MAP  = '0,
    parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MASK = '0,
    parameter logic [N_PORTS-1:0]        CONN_MASK = '1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       src_hready,
    output logic                       src_hready_resp,
    output logic                       src_hresp,
    input  logic [W_ADDR-1:0]          src_haddr,
    input  logic                       src_hwrite,
    input  logic [1:0]                 src_htrans,
    input  logic [2:0]                 src_hsize,
    input  logic [2:0]                 src_hburst,
    input  logic [3:0]                 src_hprot,
    input  logic                       src_hmastlock,
    input  logic                       src_hexcl,
    input  logic [7:0]                 src_hmaster,
    input  logic [W_DATA-1:0]          src_hwdata,
    output logic [W_DATA-1:0]          src_hrdata,
    output logic                       src_hexokay,
    output logic [N_PORTS-1:0]         dst_hready,
    input  logic [N_PORTS-1:0]         dst_hready_resp,
    input  logic [N_PORTS-1:0]         dst_hresp,
    output logic [N_PORTS*W_ADDR-1:0]  dst_haddr,
    output logic [N_PORTS-1:0]         dst_hwrite,
    output logic [N_PORTS*2-1:0]       dst_htrans,
    output logic [N_PORTS*3-1:0]       dst_hsize,
    output logic [N_PORTS*3-1:0]       dst_hburst,
    output logic [N_PORTS*4-1:0]       dst_hprot,
    output logic [N_PORTS-1:0]         dst_hmastlock,
    output logic [N_PORTS-1:0]         dst_hexcl,
    output logic [N_PORTS*8-1:0]       dst_hmaster,
    output logic [N_PORTS*W_DATA-1:0]  dst_hwdata,
    input  logic [N_PORTS*W_DATA-1:0]  dst_hrdata,
    input  logic [N_PORTS-1:0]         dst_hexokay,
    output logic [N_PORTS-1:0]         slave_sel_d
`ifdef AHBL_SPLITTER_DECERR_LOG_EN
    ,
    output logic [W_ADDR-1:0]          decerr_addr,
    output logic                       decerr_valid
`endif
);

    localparam int unsigned W_RESP = W_DATA + 3;

    logic [N_PORTS-1:0]        w_hit;
    logic [N_PORTS-1:0]        w_sel_a;
    logic                      w_decerr_a;
    logic [N_PORTS-1:0]        r_slave_sel_d;
    logic                      r_err_d;
    logic                      w_ds_hready_resp;
    logic                      w_ds_hresp;
    logic                      w_ds_err_active;
    logic [N_PORTS*W_RESP-1:0] w_resp_bus;
    logic [W_RESP-1:0]         w_resp_mux;

    // Per-port address match against the masked base address.
    always_comb begin
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            w_hit[i] = CONN_MASK[i] &&
                (((src_haddr ^ ADDR_MAP[i*W_ADDR +: W_ADDR]) &
                  ADDR_MASK[i*W_ADDR +: W_ADDR]) == '0);
        end
    end

    // x & -x isolates the lowest set bit, so overlapping maps go to the lowest port.
    assign w_sel_a    = (w_hit & (-w_hit)) & {N_PORTS{src_htrans[1]}};
    assign w_decerr_a = src_htrans[1] && !(|w_hit);

    assign dst_hready    = {N_PORTS{src_hready}};
    assign dst_haddr     = {N_PORTS{src_haddr}};
    assign dst_hwrite    = {N_PORTS{src_hwrite}};
    assign dst_hsize     = {N_PORTS{src_hsize}};
    assign dst_hburst    = {N_PORTS{src_hburst}};
    assign dst_hprot     = {N_PORTS{src_hprot}};
    assign dst_hmastlock = {N_PORTS{src_hmastlock}};
    assign dst_hexcl     = {N_PORTS{src_hexcl}};
    assign dst_hmaster   = {N_PORTS{src_hmaster}};
    assign dst_hwdata    = {N_PORTS{src_hwdata}};

    // Only the selected port sees a real transfer; everyone else sees IDLE.
    always_comb begin
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            dst_htrans[i*2 +: 2] = w_sel_a[i] ? src_htrans : HTRANS_IDLE;
        end
    end

    // Data-phase select and error flag advance only when the bus is ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slave_sel_d <= '0;
            r_err_d       <= 1'b0;
        end else if (src_hready) begin
            r_slave_sel_d <= w_sel_a;
            r_err_d       <= w_decerr_a;
        end
    end

    assign slave_sel_d = r_slave_sel_d;

    ahbl_default_slave u_default_slave (
        .clk         (clk),
        .rst         (rst),
        .hready      (src_hready),
        .decerr_a    (w_decerr_a),
        .hready_resp (w_ds_hready_resp),
        .hresp       (w_ds_hresp),
        .err_active  (w_ds_err_active)
    );

    // Pack each port's response fields into one lane for a single mux.
    always_comb begin
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            w_resp_bus[i*W_RESP +: W_RESP] = {dst_hready_resp[i], dst_hresp[i],
                                              dst_hexokay[i], dst_hrdata[i*W_DATA +: W_DATA]};
        end
    end

    onehot_mux #(
        .N (N_PORTS),
        .W (W_RESP)
    ) u_resp_mux (
        .sel  (r_slave_sel_d),
        .din  (w_resp_bus),
        .dout (w_resp_mux)
    );

    // Upstream response: default slave during errors, selected slave, else idle OKAY.
    always_comb begin
        if (r_err_d || w_ds_err_active) begin
            src_hready_resp = w_ds_hready_resp;
            src_hresp       = w_ds_hresp;
            src_hexokay     = 1'b0;
            src_hrdata      = '0;
        end else if (|r_slave_sel_d) begin
            {src_hready_resp, src_hresp, src_hexokay, src_hrdata} = w_resp_mux;
        end else begin
            src_hready_resp = 1'b1;
            src_hresp       = HRESP_OKAY;
            src_hexokay     = 1'b0;
            src_hrdata      = '0;
        end
    end

`ifdef AHBL_SPLITTER_DECERR_LOG_EN
    logic [W_ADDR-1:0] r_decerr_addr;
    logic              r_decerr_valid;

    // Sticky log of the first decode error since reset; later errors are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_decerr_addr  <= '0;
            r_decerr_valid <= 1'b0;
        end else if (src_hready && w_decerr_a && !r_decerr_valid) begin
            r_decerr_addr  <= src_haddr;
            r_decerr_valid <= 1'b1;
        end
    end

    assign decerr_addr  = r_decerr_addr;
    assign decerr_valid = r_decerr_valid;
`endif

endmodule

// File: tb/tb_ahbl_splitter.sv
// Self-checking bench for ahbl_splitter: scoreboard of expected data-phase responses.
// Builds with or without AHBL_SPLITTER_DECERR_LOG_EN.
module tb_ahbl_splitter;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        src_hready;
    logic        src_hready_resp;
    logic        src_hresp;
    logic [31:0] src_haddr = '0;
    logic        src_hwrite = 1'b0;
    logic [1:0]  src_htrans = T_IDLE;
    logic [2:0]  src_hsize = 3'd2;
    logic [2:0]  src_hburst = 3'd0;
    logic [3:0]  src_hprot = 4'd3;
    logic        src_hmastlock = 1'b0;
    logic        src_hexcl = 1'b0;
    logic [7:0]  src_hmaster = 8'h11;
    logic [31:0] src_hwdata = '0;
    logic [31:0] src_hrdata;
    logic        src_hexokay;
    logic [1:0]  dst_hready;
    logic [1:0]  dst_hready_resp;
    logic [1:0]  dst_hresp;
    logic [63:0] dst_haddr;
    logic [1:0]  dst_hwrite;
    logic [3:0]  dst_htrans;
    logic [5:0]  dst_hsize;
    logic [5:0]  dst_hburst;
    logic [7:0]  dst_hprot;
    logic [1:0]  dst_hmastlock;
    logic [1:0]  dst_hexcl;
    logic [15:0] dst_hmaster;
    logic [63:0] dst_hwdata;
    logic [63:0] dst_hrdata;
    logic [1:0]  dst_hexokay;
    logic [1:0]  slave_sel_d;
`ifdef AHBL_SPLITTER_DECERR_LOG_EN
    logic [31:0] decerr_addr;
    logic        decerr_valid;
`endif

    // Single master: the global HREADY is the splitter's own HREADYOUT.
    assign src_hready = src_hready_resp;

    always #5 clk = ~clk;

    ahbl_splitter #(
        .N_PORTS   (2),
        .W_ADDR    (32),
        .W_DATA    (32),
        .ADDR_MAP  ({32'h2000_0000, 32'h0000_0000}),
        .ADDR_MASK ({32'hF000_0000, 32'hF000_0000}),
        .CONN_MASK (2'b11)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .src_hready      (src_hready),
        .src_hready_resp (src_hready_resp),
        .src_hresp       (src_hresp),
        .src_haddr       (src_haddr),
        .src_hwrite      (src_hwrite),
        .src_htrans      (src_htrans),
        .src_hsize       (src_hsize),
        .src_hburst      (src_hburst),
        .src_hprot       (src_hprot),
        .src_hmastlock   (src_hmastlock),
        .src_hexcl       (src_hexcl),
        .src_hmaster     (src_hmaster),
        .src_hwdata      (src_hwdata),
        .src_hrdata      (src_hrdata),
        .src_hexokay     (src_hexokay),
        .dst_hready      (dst_hready),
        .dst_hready_resp (dst_hready_resp),
        .dst_hresp       (dst_hresp),
        .dst_haddr       (dst_haddr),
        .dst_hwrite      (dst_hwrite),
        .dst_htrans      (dst_htrans),
        .dst_hsize       (dst_hsize),
        .dst_hburst      (dst_hburst),
        .dst_hprot       (dst_hprot),
        .dst_hmastlock   (dst_hmastlock),
        .dst_hexcl       (dst_hexcl),
        .dst_hmaster     (dst_hmaster),
        .dst_hwdata      (dst_hwdata),
        .dst_hrdata      (dst_hrdata),
        .dst_hexokay     (dst_hexokay),
        .slave_sel_d     (slave_sel_d)
`ifdef AHBL_SPLITTER_DECERR_LOG_EN
        ,
        .decerr_addr     (decerr_addr),
        .decerr_valid    (decerr_valid)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Read data the behavioural slaves return; port 1 at 0x2000_0010 gives 0xDEADBEEF.
    function automatic logic [31:0] slv_rdata(input int p, input logic [31:0] a);
        return (p == 1) ? (a ^ 32'hFEAD_BEFF) : (a ^ 32'h1234_5678);
    endfunction

    // Behavioural downstream slaves with a programmable number of wait states.
    int          ws[2];
    logic        s_act[2];
    int          s_cnt[2];
    logic [31:0] s_addr[2];
    logic        s_excl[2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                s_act[p]  <= 1'b0;
                s_cnt[p]  <= 0;
                s_addr[p] <= '0;
                s_excl[p] <= 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (dst_hready[p]) begin
                    s_act[p]  <= dst_htrans[2*p+1];
                    s_cnt[p]  <= 0;
                    s_addr[p] <= dst_haddr[32*p +: 32];
                    s_excl[p] <= dst_hexcl[p];
                end else if (s_act[p]) begin
                    s_cnt[p] <= s_cnt[p] + 1;
                end
            end
        end
    end

    always_comb begin
        dst_hready_resp = '1;
        dst_hresp       = '0;
        dst_hexokay     = '0;
        dst_hrdata      = '0;
        for (int p = 0; p < 2; p++) begin
            dst_hready_resp[p]       = !s_act[p] || (s_cnt[p] >= ws[p]);
            dst_hexokay[p]           = s_act[p] && s_excl[p];
            dst_hrdata[32*p +: 32]   = s_act[p] ? slv_rdata(p, s_addr[p]) : 32'h0;
        end
    end

    // Scoreboard of outstanding data phases.
    typedef struct {
        logic        err;
        logic        wr;
        int          port;
        logic [31:0] rdata;
        logic [31:0] wdata;
        logic [1:0]  sel;
        int          waits;
        logic        exok;
    } item_t;

    item_t q[$];
    item_t cur;
    int    wcnt = 0;
    logic  dp_active;

    // Protocol view of whether a data phase is in progress.
    always @(posedge clk or posedge rst) begin
        if (rst) dp_active <= 1'b0;
        else if (src_hready) dp_active <= src_htrans[1];
    end

    // Monitor: compare each data-phase cycle against the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && dp_active) begin
                if (q.size() == 0) begin
                    chk("sb_underflow", 32'(q.size()), 32'd1);
                end else begin
                    cur = q[0];
                    chk("sel_d", 32'(slave_sel_d), 32'(cur.sel));
                    if (!src_hready_resp) begin
                        wcnt++;
                        if (cur.err) chk("err1_hresp", 32'(src_hresp), 32'd1);
                        if (cur.wr && !cur.err)
                            chk("hwdata_stall", dst_hwdata[32*cur.port +: 32], cur.wdata);
                    end else begin
                        chk("hresp", 32'(src_hresp), 32'(cur.err));
                        chk("waits", 32'(wcnt), 32'(cur.waits));
                        chk("hexokay", 32'(src_hexokay), 32'(cur.exok));
                        if (!cur.wr) chk("hrdata", src_hrdata, cur.rdata);
                        if (cur.wr && !cur.err)
                            chk("hwdata", dst_hwdata[32*cur.port +: 32], cur.wdata);
                        wcnt = 0;
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    // Drive one NSEQ address phase, check the gated htrans, push the expected response.
    task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                         input logic excl);
        item_t it;
        int    t;
        src_haddr  = addr;
        src_hwrite = wr;
        src_htrans = T_NSEQ;
        src_hexcl  = excl;
        it.err   = 1'b0;
        it.port  = 0;
        if (addr[31:28] == 4'h2) it.port = 1;
        else if (addr[31:28] != 4'h0) it.err = 1'b1;
        it.wr    = wr;
        it.wdata = wdata;
        it.sel   = it.err ? 2'b00 : ((it.port == 1) ? 2'b10 : 2'b01);
        it.waits = it.err ? 1 : ws[it.port];
        it.rdata = it.err ? 32'h0 : slv_rdata(it.port, addr);
        it.exok  = !it.err && excl;
        #1;
        chk("htrans0", 32'(dst_htrans[1:0]), (it.sel[0]) ? 32'(T_NSEQ) : 32'(T_IDLE));
        chk("htrans1", 32'(dst_htrans[3:2]), (it.sel[1]) ? 32'(T_NSEQ) : 32'(T_IDLE));
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!src_hready && t < 50);
        chk("accept_timeout", 32'(src_hready), 32'd1);
        q.push_back(it);
        @(posedge clk);
        #1;
        src_hwdata = wr ? wdata : 32'h0;
        src_htrans = T_IDLE;
        src_hexcl  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || dp_active) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid data phase and check the upstream response clears at once.
    task automatic reset_mid(input string tag);
        #1;
        rst = 1'b1;
        #1;
        chk({tag, "_rdy"}, 32'(src_hready_resp), 32'd1);
        chk({tag, "_resp"}, 32'(src_hresp), 32'd0);
        chk({tag, "_sel"}, 32'(slave_sel_d), 32'd0);
        q.delete();
        wcnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ws[0] = 0;
        ws[1] = 0;
        #2;
        chk("rst_hready_resp", 32'(src_hready_resp), 32'd1);
        chk("rst_hresp", 32'(src_hresp), 32'd0);
        chk("rst_hexokay", 32'(src_hexokay), 32'd0);
        chk("rst_hrdata", src_hrdata, 32'd0);
        chk("rst_dst_htrans", 32'(dst_htrans), 32'd0);
        chk("rst_sel_d", 32'(slave_sel_d), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Mapped read to port 1, then an unmapped access.
        issue(32'h2000_0010, 1'b0, 32'h0, 1'b0);
        issue(32'h5000_0000, 1'b0, 32'h0, 1'b0);
        drain();

        // Stalled write on port 0.
        ws[0] = 3;
        issue(32'h0000_0100, 1'b1, 32'hA5A5_A5A5, 1'b0);
        drain();
        ws[0] = 0;

        // Back-to-back: port0, port1, unmapped, port0, then two errors in a row.
        ws[1] = 1;
        issue(32'h0000_0040, 1'b0, 32'h0, 1'b1);
        issue(32'h2000_0044, 1'b1, 32'h1357_9BDF, 1'b0);
        issue(32'h7000_0000, 1'b0, 32'h0, 1'b0);
        issue(32'h0000_0048, 1'b0, 32'h0, 1'b0);
        issue(32'h9000_0000, 1'b1, 32'h0BAD_F00D, 1'b0);
        issue(32'hA000_0000, 1'b0, 32'h0, 1'b0);
        issue(32'h2000_0080, 1'b0, 32'h0, 1'b1);
        drain();
        ws[1] = 0;

        // BUSY to an unmapped address must not raise an error.
        src_haddr  = 32'h5000_0000;
        src_htrans = T_BUSY;
        #1;
        chk("busy_htrans", 32'(dst_htrans), 32'd0);
        @(posedge clk);
        #1;
        src_htrans = T_IDLE;
        @(negedge clk);
        chk("busy_rdy", 32'(src_hready_resp), 32'd1);
        chk("busy_resp", 32'(src_hresp), 32'd0);
        @(posedge clk);
        #1;

        // Reset while the default slave is in ERR1.
        issue(32'h5000_0008, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("pre_rst_err1", 32'(src_hready_resp), 32'd0);
        reset_mid("rst_err1");

        // Reset while port 1 stalls.
        ws[1] = 5;
        issue(32'h2000_0020, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("pre_rst_sel", 32'(slave_sel_d), 32'd2);
        reset_mid("rst_stall");
        ws[1] = 0;
        @(posedge clk);
        #1;

`ifdef AHBL_SPLITTER_DECERR_LOG_EN
        chk("log_valid_rst", 32'(decerr_valid), 32'd0);
        issue(32'h5000_0004, 1'b0, 32'h0, 1'b0);
        issue(32'h6000_0000, 1'b0, 32'h0, 1'b0);
        drain();
        chk("log_valid", 32'(decerr_valid), 32'd1);
        chk("log_addr", decerr_addr, 32'h5000_0004);
`endif

        // Traffic still flows after the mid-transfer resets.
        issue(32'h2000_0010, 1'b0, 32'h0, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ahbl_splitter.md
Name: ahbl_splitter

Overview:
1:N AHB-Lite address decoder and splitter; the counterpart of the N:1 arbiter.
- One upstream master-facing slave port fans out to N_PORTS downstream slave ports, selected by address match.
- Data-phase responses are muxed back to the upstream port.
- Unmapped accesses go to an internal default slave, which returns a two-cycle ERROR response.
- Exports the registered data-phase select so that an upstream arbiter can detect in-flight accesses per port.

Parameters:
N_PORTS, 2, number of downstream slave ports
W_ADDR, 32, address width
W_DATA, 32, data width
ADDR_MAP, {N_PORTS{32'h0}}, concatenated base address per port; port i occupies bits [i*W_ADDR +: W_ADDR]
ADDR_MASK, {N_PORTS{32'h0}}, concatenated decode mask per port; 1 = bit participates in decode
CONN_MASK, {N_PORTS{1'b1}}, port i is decodable only if bit i is set

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
src_hready  in  1  global HREADY seen by this port
src_hready_resp  out  1  upstream HREADYOUT
src_hresp  out  1  upstream HRESP
src_haddr  in  W_ADDR  address
src_hwrite  in  1  write
src_htrans  in  2  transfer type
src_hsize  in  3  size
src_hburst  in  3  burst
src_hprot  in  4  protection
src_hmastlock  in  1  locked
src_hexcl  in  1  exclusive request
src_hmaster  in  8  master ID
src_hwdata  in  W_DATA  write data
src_hrdata  out  W_DATA  read data
src_hexokay  out  1  exclusive okay
dst_hready  out  N_PORTS  HREADY to each slave
dst_hready_resp  in  N_PORTS  HREADYOUT from each slave
dst_hresp  in  N_PORTS  HRESP from each slave
dst_haddr  out  N_PORTS*W_ADDR  broadcast address
dst_hwrite  out  N_PORTS  broadcast write
dst_htrans  out  N_PORTS*2  gated transfer type
dst_hsize  out  N_PORTS*3  broadcast size
dst_hburst  out  N_PORTS*3  broadcast burst
dst_hprot  out  N_PORTS*4  broadcast protection
dst_hmastlock  out  N_PORTS  broadcast lock
dst_hexcl  out  N_PORTS  broadcast exclusive request
dst_hmaster  out  N_PORTS*8  broadcast master ID
dst_hwdata  out  N_PORTS*W_DATA  broadcast write data
dst_hrdata  in  N_PORTS*W_DATA  read data from each slave
dst_hexokay  in  N_PORTS  exclusive okay from each slave
slave_sel_d  out  N_PORTS  registered one-hot data-phase select

Behaviour:
Address-phase decode (combinational):
- hit[i] = CONN_MASK[i] && ((src_haddr ^ ADDR_MAP[i]) & ADDR_MASK[i]) == 0.
- slave_sel_a = lowest-index set bit of hit, qualified by src_htrans[1]. Overlapping maps resolve to the lowest index.
- decerr_a = src_htrans[1] && !|hit.

Downstream address-phase signals:
- All address-phase signals are broadcast to every port unchanged, except htrans.
- dst_htrans[i] = slave_sel_a[i] ? src_htrans : IDLE (2'b00).
- dst_hready[i] = src_hready for all i.
- dst_hwdata is a broadcast of src_hwdata.

Data-phase registers (updated only when src_hready=1):
- slave_sel_d <= slave_sel_a.
- err_d <= decerr_a.
- On reset: slave_sel_d = 0, err_d = 0.

Default-slave FSM (states IDLE, ERR1, ERR2):
- IDLE: if src_hready && decerr_a, go to ERR1.
- ERR1: hready_resp=0, hresp=1; go to ERR2 unconditionally.
- ERR2: hready_resp=1, hresp=1. If src_hready && decerr_a, go to ERR1 (back-to-back error); otherwise go to IDLE.
- Reset state: IDLE.

Upstream response:
- If slave_sel_d = 0 and not in an ERR state: hready_resp=1, hresp=0, hexokay=0, hrdata=0.
- Otherwise, hready_resp, hresp, hexokay and hrdata are one-hot muxed by slave_sel_d.

Reset values:
- src_hready_resp=1, src_hresp=0, src_hexokay=0, src_hrdata=0.
- dst_htrans all IDLE.
- slave_sel_d=0.

Latency and boundary conditions:
- Zero added cycles for mapped accesses; decode is purely combinational.
- Stalled data phase (selected slave hready_resp=0): slave_sel_d holds, and the new address is presented but not yet registered.
- Reset mid-transfer: FSM and selects clear immediately (asynchronous).
- IDLE or BUSY htrans never triggers an error.

Optional Feature:
AHBL_SPLITTER_DECERR_LOG_EN
- With the macro: adds outputs decerr_addr (W_ADDR) and decerr_valid (1).
  - On the first IDLE→ERR1 transition, capture src_haddr from the address phase and set decerr_valid.
  - Both outputs are sticky until rst; later errors do not overwrite them.
- Without the macro: these ports and registers are absent.

Decomposition:
- Shared package ahbl_pkg holds:
  - HTRANS_IDLE/BUSY/NSEQ/SEQ constants;
  - HRESP_OKAY/ERROR constants;
  - default-slave state encodings.
- Response muxing reuses the existing onehot_mux.
- One sub-module, ahbl_default_slave, contains the ERR FSM. Its inputs are clk, rst, hready, decerr_a; its outputs are hready_resp, hresp, err_active.

Test Plan:
1. N_PORTS=2, ADDR_MAP={32'h2000_0000,32'h0}, ADDR_MASK={32'hF000_0000,32'hF000_0000}; NSEQ read to 0x2000_0010, port1 returns 0xDEADBEEF -> dst_htrans[3:2]=NSEQ, dst_htrans[1:0]=IDLE, src_hrdata=0xDEADBEEF next cycle, slave_sel_d=2'b10.
2. NSEQ to 0x5000_0000 (unmapped) -> cycle+1: hready_resp=0, hresp=1; cycle+2: hready_resp=1, hresp=1; no dst_htrans asserted.
3. Port0 holds hready_resp=0 for 3 cycles during a write of 0xA5A5A5A5 -> src_hready_resp=0 for 3 cycles; slave_sel_d stable at 2'b01; dst_hwdata stable.
4. Back-to-back NSEQ port0 → port1 → unmapped → port0 -> responses are correctly ordered; error takes exactly 2 cycles; no dropped transfer.
5. Assert rst while in ERR1 -> hready_resp=1, hresp=0, slave_sel_d=0 immediately without waiting for a clock edge.
6. With AHBL_SPLITTER_DECERR_LOG_EN, errors at 0x5000_0004 then 0x6000_0000 -> decerr_valid=1, decerr_addr=0x5000_0004.
